// File: rtl/mult_rr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mult_sched_pkg
// Shared constants, types and helpers for the round-robin multiplier
// scheduler (mult_rr_scheduler) and its arbiter (rr_arbiter).
//   W_DEF    : default operand width
//   LAT_DEF  : default multiplier latency in clock edges
//   NREQ_DEF : default number of requesters
//   IDW      : requester-id width for the default requester count (>= 1)
//   tag_t    : one tag-pipeline stage {vld, id} at the default id width
//   id_width : id width for an arbitrary requester count (>= 1)
// ---------------------------------------------------------------------------
package mult_sched_pkg;

  localparam int W_DEF    = 8;
  localparam int LAT_DEF  = 3;
  localparam int NREQ_DEF = 4;

  // A single requester still needs a 1-bit id so that vectors stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW = id_width(NREQ_DEF);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// mult_rr_scheduler_if
// Bundles the requester handshake, the shared-multiplier operand/result bus
// and the response/status outputs of mult_rr_scheduler.
//   master : client side (requesters + external multiplier) - drives
//            req_valid/req_a/req_b and mul_y
//   slave  : scheduler side - drives req_ready, mul_a/mul_b, rsp_valid,
//            rsp_y and inflight
// ---------------------------------------------------------------------------
interface mult_rr_scheduler_if
  import mult_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int LAT  = LAT_DEF
);

  localparam int CW = $clog2(LAT + 1);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_y;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_y;
  logic [CW-1:0]     inflight;

  modport master (
    output req_valid, req_a, req_b, mul_y,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_y, inflight
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_y,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_y, inflight
  );

endinterface

// File: rtl/mult_rr_scheduler_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter, usable for any shared resource.
// Scans req starting at ptr (ptr, ptr+1, ... mod N) and grants the first
// set bit.
//   req    : in  N            request vector
//   ptr    : in  id_width(N)  scan start position (must be < N)
//   gnt    : out N            one-hot grant, all zero when no request
//   gnt_id : out id_width(N)  binary index of the granted bit
// ---------------------------------------------------------------------------
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic [N-1:0]              req,
  input  logic [id_width(N)-1:0]    ptr,
  output logic [N-1:0]              gnt,
  output logic [id_width(N)-1:0]    gnt_id
);

  localparam int IDW = id_width(N);
  // One extra bit so ptr + offset never overflows before the wrap.
  localparam int PW  = IDW + 1;

  logic [PW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest valid requester
  // is the last (winning) assignment.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    pos    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && (pos == PW'(i))) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          gnt_id = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mult_rr_scheduler
// Shares one external fixed-latency W x W multiplier among NREQ requesters.
// At most one requester is granted per cycle (round robin); its operands are
// registered onto mul_a/mul_b and a {vld,id} tag enters a LAT-deep shift
// register so the product coming back on mul_y is steered to the issuer.
//   clk      : in   clock, rising edge
//   rst_n    : in   asynchronous active-low reset
//   bus      : slave modport of mult_rr_scheduler_if
//     req_valid/req_a/req_b in, req_ready out (combinational grant)
//     mul_a/mul_b out (registered), mul_y in
//     rsp_valid/rsp_y out (rsp_y is mul_y passed through), inflight out
// ---------------------------------------------------------------------------
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_rr_scheduler_if.slave bus
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(LAT + 1);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } stage_t;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            xfer;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]    mul_a_q, mul_a_d;
  logic [W-1:0]    mul_b_q, mul_b_d;
  stage_t          tag_q [LAT];
  stage_t          tag_d0;
  logic [CW-1:0]   inflight_q, inflight_d;

  logic [W-1:0]    a_lane [NREQ];
  logic [W-1:0]    b_lane [NREQ];
  logic [W-1:0]    a_sel, b_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The grant is one-hot whenever any request is valid.
  assign xfer = |bus.req_valid;

  // AND-OR operand mux driven directly by the one-hot grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign a_lane[gi] = bus.req_a[gi*W +: W] & {W{gnt[gi]}};
    assign b_lane[gi] = bus.req_b[gi*W +: W] & {W{gnt[gi]}};
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = a_sel | a_lane[i];
      b_sel = b_sel | b_lane[i];
    end
  end

  always_comb begin
    // Idle cycles keep the operands frozen to avoid multiplier toggling.
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    ptr_d   = ptr_q;
    tag_d0  = '0;
    if (xfer) begin
      mul_a_d    = a_sel;
      mul_b_d    = b_sel;
      tag_d0.vld = 1'b1;
      tag_d0.id  = gnt_id;
      ptr_d      = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
    // One tag enters, the oldest one leaves: the count of vld bits follows.
    inflight_d = inflight_q + CW'(xfer) - CW'(tag_q[LAT-1].vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      inflight_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      inflight_q <= inflight_d;
      tag_q[0]   <= tag_d0;
      for (int s = 1; s < LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign bus.rsp_valid[gi] = tag_q[LAT-1].vld && (tag_q[LAT-1].id == IDW'(gi));
  end

  assign bus.req_ready = gnt;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_y     = bus.mul_y;
  assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mult_rr_scheduler
// Directed bench for mult_rr_scheduler (NREQ=4, W=8, LAT=3) with an exact
// 3-edge multiplier model on mul_y and a scoreboard of expected responses.
// ---------------------------------------------------------------------------
module tb_mult_rr_scheduler;
  import mult_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 3;

  typedef struct {
    int          id;
    logic [15:0] y;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_rr_scheduler_if #(.NREQ(NREQ), .W(W), .LAT(LAT)) bus ();

  mult_rr_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Exact multiplier: product visible LAT-1 edges after the operand edge.
  logic [15:0] p1_q, p2_q;
  always @(posedge clk) begin
    p1_q <= 16'(bus.mul_a) * 16'(bus.mul_b);
    p2_q <= p1_q;
  end
  assign bus.mul_y = p2_q;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   quiet = 1'b0;
  exp_t sb [$];
  logic [7:0] last_a = '0;
  logic [7:0] last_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] v0, input logic [7:0] v1,
                                        input logic [7:0] v2, input logic [7:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // Response monitor: every cycle must either carry the oldest expected
  // response (exact cycle, id and product) or be silent.
  always @(negedge clk) begin
    logic [NREQ-1:0] oh;
    check_val("inflight", 32'(bus.inflight), 32'(sb.size()));
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      oh = NREQ'(1) << sb[0].id;
      check_val("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      check_val("rsp_y", 32'(bus.rsp_y), 32'(sb[0].y));
      if (!quiet) $display("rsp  id=%0d y=%0d cycle=%0d", sb[0].id, bus.rsp_y, cyc);
      void'(sb.pop_front());
    end else begin
      check_val("rsp_idle", 32'(bus.rsp_valid), 32'd0);
    end
  end

  // One cycle of stimulus, entered and left at negedge+1.
  // g is the expected granted requester (-1 = none), ey its product.
  task automatic drive(input logic [3:0] vmask, input int g, input logic [31:0] apk,
                       input logic [31:0] bpk, input logic [15:0] ey, input string tg);
    logic [3:0] er;
    exp_t       e;
    bus.req_valid = vmask;
    bus.req_a     = apk;
    bus.req_b     = bpk;
    #1;
    er = (g < 0) ? 4'b0000 : (4'b0001 << g);
    check_val({tg, "/ready"}, 32'(bus.req_ready), 32'(er));
    if (g >= 0) begin
      e.id  = g;
      e.y   = ey;
      e.cyc = cyc + LAT;
      sb.push_back(e);
      last_a = apk[g*W +: W];
      last_b = bpk[g*W +: W];
      if (!quiet) $display("xfer %s id=%0d a=%0d b=%0d cycle=%0d", tg, g, last_a, last_b, cyc);
    end
    @(negedge clk);
    #1;
    check_val({tg, "/mul_a"}, 32'(bus.mul_a), 32'(last_a));
    check_val({tg, "/mul_b"}, 32'(bus.mul_b), 32'(last_b));
  endtask

  task automatic idle(input int n, input string tg);
    for (int i = 0; i < n; i++) drive(4'b0000, -1, 32'd0, 32'd0, 16'd0, tg);
  endtask

  initial begin
    int cont_y [4] = '{10, 20, 30, 40};
    logic [7:0] sa, sbv;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst/mul_a", 32'(bus.mul_a), 32'd0);
    check_val("rst/mul_b", 32'(bus.mul_b), 32'd0);
    check_val("rst/inflight", 32'(bus.inflight), 32'd0);
    check_val("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("rst/ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;

    // Full contention from ptr=0: grants 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++)
      drive(4'b1111, c % 4, pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd10, 8'd10, 8'd10, 8'd10),
            16'(cont_y[c % 4]), "contend");
    idle(4, "idle");

    // Single requester 2: 23*67 = 1541.
    drive(4'b0100, 2, pack4(8'd0, 8'd0, 8'd23, 8'd0), pack4(8'd0, 8'd0, 8'd67, 8'd0), 16'd1541, "single");
    idle(4, "idle");

    // Pointer skip: ptr=3 -> grant 0 (ptr=1), then {0,3} valid -> 3, then 0, then ptr=1 seen.
    drive(4'b0001, 0, pack4(8'd6, 8'd0, 8'd0, 8'd0), pack4(8'd6, 8'd0, 8'd0, 8'd0), 16'd36, "ptr_set");
    drive(4'b1001, 3, pack4(8'd9, 8'd0, 8'd0, 8'd5), pack4(8'd9, 8'd0, 8'd0, 8'd7), 16'd35, "skip3");
    drive(4'b0001, 0, pack4(8'd9, 8'd0, 8'd0, 8'd0), pack4(8'd9, 8'd0, 8'd0, 8'd0), 16'd81, "skip0");
    drive(4'b1111, 1, pack4(8'd1, 8'd12, 8'd1, 8'd1), pack4(8'd1, 8'd12, 8'd1, 8'd1), 16'd144, "ptr_chk");
    idle(4, "idle");

    // Operand hold: 255*255 then 5 idle cycles with mul_a/mul_b frozen.
    drive(4'b0001, 0, pack4(8'd255, 8'd0, 8'd0, 8'd0), pack4(8'd255, 8'd0, 8'd0, 8'd0), 16'd65025, "hold");
    idle(5, "hold_idle");

    // Reset mid-flight: three issues, the first answer lands, then reset drops the rest.
    drive(4'b0010, 1, pack4(8'd0, 8'd2, 8'd0, 8'd0), pack4(8'd0, 8'd3, 8'd0, 8'd0), 16'd6, "pre_rst");
    drive(4'b0010, 1, pack4(8'd0, 8'd3, 8'd0, 8'd0), pack4(8'd0, 8'd3, 8'd0, 8'd0), 16'd9, "pre_rst");
    drive(4'b0010, 1, pack4(8'd0, 8'd4, 8'd0, 8'd0), pack4(8'd0, 8'd3, 8'd0, 8'd0), 16'd12, "pre_rst");
    rst_n = 1'b0;
    sb.delete();
    last_a = '0;
    last_b = '0;
    #1;
    check_val("in_rst/inflight", 32'(bus.inflight), 32'd0);
    check_val("in_rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    idle(3, "in_rst");
    rst_n = 1'b1;
    idle(2, "post_rst_idle");
    drive(4'b1000, 3, pack4(8'd0, 8'd0, 8'd0, 8'd11), pack4(8'd0, 8'd0, 8'd0, 8'd13), 16'd143, "post_rst");
    idle(4, "idle");

    // Sweep: requester 2 streams every (a,b) pair back to back.
    quiet = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      sa  = k[15:8];
      sbv = k[7:0];
      drive(4'b0100, 2, {8'd0, sa, 16'd0}, {8'd0, sbv, 16'd0}, 16'(sa) * 16'(sbv), "sweep");
    end
    idle(LAT + 1, "sweep_drain");
    quiet = 1'b0;
    $display("sweep 65536 pairs streamed through requester 2, bad so far=%0d", bad);

    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler that shares one 8x8 multiplier instance (`mult_wrapper`, any approximate or exact variant) among `NREQ` requesters. Each cycle it grants at most one requester through a valid/ready handshake and registers that requester's operands into the multiplier. It carries a tag pipeline matched to the multiplier's fixed latency, so each product is returned to the requester that issued it. The block sits between client datapaths (error-sweep engines, filter taps) and the single shared multiplier.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; 2..16.
- `W`, 8: operand width; products are `2*W` bits.
- `LAT`, 3: clock edges from operand-register update to a valid `mul_y`; 1..8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  NREQ*W  packed operand B, same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot grant, combinational from `req_valid` and the pointer.
- `mul_a`  out  W  registered operand to the multiplier's `inA`.
- `mul_b`  out  W  registered operand to the multiplier's `inB`.
- `mul_y`  in  2*W  multiplier result `Y`.
- `rsp_valid`  out  NREQ  one-hot response strobe; a single cycle per accepted request.
- `rsp_y`  out  2*W  product; valid only when `rsp_valid` is non-zero.
- `inflight`  out  clog2(LAT+1)  number of accepted requests not yet answered.

## Operation
- Arbitration:
  - Scan starts at pointer `ptr`. Grant the first i, in order ptr, ptr+1, … mod NREQ, with `req_valid[i]`=1.
  - `req_ready[i]`=1 only for that i. All bits are 0 when no request is valid.
- Handshake:
  - A transfer occurs on a rising edge with `req_valid[i] & req_ready[i]`.
  - A requester holds `req_valid` and its operands stable until its transfer.
  - `req_ready` may depend on `req_valid`. A requester must not make `req_valid` depend on `req_ready`.
- On a transfer from i:
  - `mul_a`/`mul_b` ← requester i's operands.
  - Tag stage 0 ← {vld=1, id=i}.
  - `ptr` ← (i+1) mod NREQ.
- On an edge with no transfer:
  - `mul_a`/`mul_b` hold their value, to minimise multiplier toggling.
  - Tag stage 0 ← vld=0.
  - `ptr` is unchanged.
- Tag pipeline:
  - `LAT` stages that shift every edge.
  - `rsp_valid[id]` = stage LAT-1 vld, combinationally. `rsp_y` = `mul_y` passed through, no register.
- Throughput is one product per cycle. There is no response backpressure; requesters must always accept `rsp_valid`.
- `inflight` is the count of vld bits across the tag stages. Its maximum is LAT.
- Reset values: `mul_a`=`mul_b`=0, all tag vld=0, `ptr`=0, `inflight`=0, `rsp_valid`=0.
- Reset asserted mid-operation drops every in-flight product. No `rsp_valid` is generated for any request accepted before the reset.
- `NREQ`=1 degenerates to `req_ready`=`req_valid`, and `ptr` stays 0.

## Timing
- Request accepted at edge t:
  - `mul_a`/`mul_b` are valid after edge t.
  - `rsp_valid[i]` and `rsp_y` are valid in the cycle following edge t+LAT−1. For LAT=3 that is the third cycle after acceptance.
- Back-to-back grants produce back-to-back responses in issue order, with no bubbles.
- Arbitration has zero latency: a requester alone with `req_valid`=1 is granted the same cycle.
- Under full load (all NREQ valid every cycle), each requester is granted exactly once per NREQ cycles.

## Structure
- Package `mult_sched_pkg`:
  - constants `W_DEF`, `LAT_DEF`, `NREQ_DEF`
  - `localparam IDW = $clog2(NREQ)`, with a minimum of 1
  - typedef `tag_t` = packed struct {logic vld; logic [IDW-1:0] id;}
- Sub-module `rr_arbiter`:
  - parameter `N`; inputs `req`, `ptr`; outputs one-hot `gnt` and binary `gnt_id`
  - purely combinational
  - reusable for other shared resources
- The top level holds the operand register, `ptr`, the tag shift register and the inflight counter. The multiplier instance lives outside this block.

## Test plan
- Single requester, LAT=3: requester 2 presents a=23, b=67 for one cycle. `req_ready[2]`=1 the same cycle, and `rsp_valid`=4'b0100 with `rsp_y`=1541 exactly 3 cycles later. Check against an exact multiplier model.
- Full contention, NREQ=4:
  - Stimulus: all `req_valid` high for 8 cycles, with operands a=i+1, b=10.
  - Grants must run 0,1,2,3,0,1,2,3.
  - Responses must run 10,20,30,40,10,20,30,40 on consecutive cycles.
- Pointer skip: `ptr`=1, and only requesters 0 and 3 are valid. Grant goes to 3, then 0. After the grant to 0, `ptr`=1.
- Operand hold: grant a=255, b=255, then idle 5 cycles. `mul_a`/`mul_b` stay at 255, and exactly one `rsp_valid` pulse appears, with `rsp_y`=65025.
- Reset mid-flight:
  - Stimulus: issue 3 requests on consecutive cycles, then assert `rst_n`=0 one cycle after the last issue.
  - During and after reset: no `rsp_valid`, `inflight`=0, `mul_a`=`mul_b`=0.
  - After release, the next request completes normally.
- Sweep: a single requester streams all 65536 (a,b) pairs back-to-back. Every response matches the model for its issue order. There are no bubbles, so the sweep takes 65536+LAT cycles.
